// File: rtl/rom_access_arbiter_if.sv
// Bus bundle between the display/aux requesters, the ROM controller and the
// character-ROM read-port arbiter.
interface rom_access_arbiter_if;
  logic       dispReq;
  logic [2:0] dispNum;
  logic [3:0] dispAddr;
  logic       dispAck;
  logic       dispValid;
  logic [7:0] dispByte;

  logic       auxReq;
  logic [2:0] auxNum;
  logic [3:0] auxAddr;
  logic       auxAck;
  logic       auxValid;
  logic [7:0] auxByte;

  logic       romReadEn;
  logic [2:0] romNum;
  logic [3:0] romAddr;
  logic [7:0] romByte;

  logic       busy;
  logic       auxStarve;

  // Arbiter side.
  modport slave (
    input  dispReq, dispNum, dispAddr, auxReq, auxNum, auxAddr, romByte,
    output dispAck, dispValid, dispByte, auxAck, auxValid, auxByte,
           romReadEn, romNum, romAddr, busy, auxStarve
  );

  // Requester / ROM-controller side.
  modport master (
    output dispReq, dispNum, dispAddr, auxReq, auxNum, auxAddr, romByte,
    input  dispAck, dispValid, dispByte, auxAck, auxValid, auxByte,
           romReadEn, romNum, romAddr, busy, auxStarve
  );
endinterface

// File: rtl/rom_access_arbiter.sv
// Fixed-priority arbiter for the single character-ROM read port: display first,
// aux in free slots, with an owner-tag pipeline that routes each returned byte.
module rom_access_arbiter #(
  parameter int ROM_LAT    = 1,
  parameter int STARVE_LIM = 16
) (
  input logic                 pixelClk,
  input logic                 reset,
  rom_access_arbiter_if.slave bus
);
  localparam logic [7:0] STARVE_LIM_B = 8'(STARVE_LIM);

  logic             disp_ack_q, aux_ack_q, rd_en_q;
  logic [2:0]       rom_num_q;
  logic [3:0]       rom_addr_q;
  logic             disp_valid_q, aux_valid_q;
  logic [7:0]       disp_byte_q, aux_byte_q;
  logic [ROM_LAT:0] tag_v_q, tag_v_d;
  logic [ROM_LAT:0] tag_o_q, tag_o_d;
  logic [7:0]       starve_cnt_q, starve_cnt_d;
  logic             starve_q, starve_d;
  logic             grant_disp, grant_aux;
  logic             ret_disp, ret_aux;

  always_comb begin
    // A pending ack blocks a second grant of the same request.
    grant_disp = bus.dispReq & ~disp_ack_q;
    grant_aux  = bus.auxReq & ~aux_ack_q & ~grant_disp;

    tag_v_d = {tag_v_q[ROM_LAT-1:0], grant_disp | grant_aux};
    tag_o_d = {tag_o_q[ROM_LAT-1:0], grant_aux};

    ret_disp = tag_v_q[ROM_LAT] & ~tag_o_q[ROM_LAT];
    ret_aux  = tag_v_q[ROM_LAT] & tag_o_q[ROM_LAT];

    if (grant_aux || !bus.auxReq)
      starve_cnt_d = 8'd0;
    else if (starve_cnt_q == 8'hFF)
      starve_cnt_d = starve_cnt_q;
    else
      starve_cnt_d = starve_cnt_q + 8'd1;

    if (grant_aux)
      starve_d = 1'b0;
    else if (starve_cnt_d >= STARVE_LIM_B)
      starve_d = 1'b1;
    else
      starve_d = starve_q;
  end

  always_ff @(posedge pixelClk or negedge reset) begin
    if (!reset) begin
      disp_ack_q   <= 1'b0;
      aux_ack_q    <= 1'b0;
      rd_en_q      <= 1'b0;
      rom_num_q    <= '0;
      rom_addr_q   <= '0;
      disp_valid_q <= 1'b0;
      aux_valid_q  <= 1'b0;
      disp_byte_q  <= '0;
      aux_byte_q   <= '0;
      tag_v_q      <= '0;
      tag_o_q      <= '0;
      starve_cnt_q <= '0;
      starve_q     <= 1'b0;
    end else begin
      disp_ack_q <= grant_disp;
      aux_ack_q  <= grant_aux;
      rd_en_q    <= grant_disp | grant_aux;
      if (grant_disp) begin
        rom_num_q  <= bus.dispNum;
        rom_addr_q <= bus.dispAddr;
      end else if (grant_aux) begin
        rom_num_q  <= bus.auxNum;
        rom_addr_q <= bus.auxAddr;
      end
      tag_v_q      <= tag_v_d;
      tag_o_q      <= tag_o_d;
      disp_valid_q <= ret_disp;
      aux_valid_q  <= ret_aux;
      if (ret_disp) disp_byte_q <= bus.romByte;
      if (ret_aux)  aux_byte_q  <= bus.romByte;
      starve_cnt_q <= starve_cnt_d;
      starve_q     <= starve_d;
    end
  end

  assign bus.dispAck   = disp_ack_q;
  assign bus.auxAck    = aux_ack_q;
  assign bus.romReadEn = rd_en_q;
  assign bus.romNum    = rom_num_q;
  assign bus.romAddr   = rom_addr_q;
  assign bus.dispValid = disp_valid_q;
  assign bus.auxValid  = aux_valid_q;
  assign bus.dispByte  = disp_byte_q;
  assign bus.auxByte   = aux_byte_q;
  assign bus.busy      = |tag_v_q;
  assign bus.auxStarve = starve_q;
endmodule

// File: tb/tb_rom_access_arbiter.sv
// Directed bench for rom_access_arbiter: ROM_LAT=1/STARVE_LIM=2 and ROM_LAT=3
// instances, byte scoreboard per requester, latency and ordering checks.
module tb_rom_access_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst3;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  rom_access_arbiter_if b1();
  rom_access_arbiter_if b3();

  rom_access_arbiter #(.ROM_LAT(1), .STARVE_LIM(2)) u_dut1 (
    .pixelClk(clk), .reset(rst1), .bus(b1.slave)
  );
  rom_access_arbiter #(.ROM_LAT(3), .STARVE_LIM(16)) u_dut3 (
    .pixelClk(clk), .reset(rst3), .bus(b3.slave)
  );

  typedef struct {
    logic [7:0] b;
    int         due;
  } exp_t;

  exp_t q1d[$], q1a[$], q3d[$], q3a[$];
  exp_t e1, e3;

  function automatic logic [7:0] romf(input logic [2:0] n, input logic [3:0] a);
    return {n, a, ^{n, a}} ^ 8'hA5;
  endfunction

  // ROM controller models: read data valid at the DUT's capture edge.
  logic [7:0] p1, p2;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    b1.romByte <= b1.romReadEn ? romf(b1.romNum, b1.romAddr) : 8'h00;
    p1 <= b3.romReadEn ? romf(b3.romNum, b3.romAddr) : 8'h00;
    p2 <= p1;
    b3.romByte <= p2;
  end

  logic [29:0] outs1;
  assign outs1 = {b1.romReadEn, b1.romNum, b1.romAddr, b1.dispAck, b1.dispValid,
                  b1.dispByte, b1.auxAck, b1.auxValid, b1.auxByte, b1.busy, b1.auxStarve};
  logic [29:0] outs3;
  assign outs3 = {b3.romReadEn, b3.romNum, b3.romAddr, b3.dispAck, b3.dispValid,
                  b3.dispByte, b3.auxAck, b3.auxValid, b3.auxByte, b3.busy, b3.auxStarve};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (b1.dispValid || b1.auxValid)
      chk("d1_single_valid", 32'(b1.dispValid & b1.auxValid), 32'd0);
    if (b1.dispValid) begin
      if (q1d.size() == 0) chk("d1_disp_unexpected_valid", 32'(b1.dispValid), 32'd0);
      else begin
        e1 = q1d.pop_front();
        chk("d1_disp_byte", 32'(b1.dispByte), 32'(e1.b));
      end
    end
    if (b1.auxValid) begin
      if (q1a.size() == 0) chk("d1_aux_unexpected_valid", 32'(b1.auxValid), 32'd0);
      else begin
        e1 = q1a.pop_front();
        chk("d1_aux_byte", 32'(b1.auxByte), 32'(e1.b));
      end
    end
  end

  always @(negedge clk) begin
    if (b3.dispValid || b3.auxValid)
      chk("d3_single_valid", 32'(b3.dispValid & b3.auxValid), 32'd0);
    if (b3.dispValid) begin
      if (q3d.size() == 0) chk("d3_disp_unexpected_valid", 32'(b3.dispValid), 32'd0);
      else begin
        e3 = q3d.pop_front();
        chk("d3_disp_byte", 32'(b3.dispByte), 32'(e3.b));
        chk("d3_disp_latency", 32'(cyc), 32'(e3.due));
      end
    end
    if (b3.auxValid) begin
      if (q3a.size() == 0) chk("d3_aux_unexpected_valid", 32'(b3.auxValid), 32'd0);
      else begin
        e3 = q3a.pop_front();
        chk("d3_aux_byte", 32'(b3.auxByte), 32'(e3.b));
        chk("d3_aux_latency", 32'(cyc), 32'(e3.due));
      end
    end
  end

  initial begin
    logic [2:0] dn, an;
    logic [3:0] da, aa;

    b1.dispReq = 0; b1.dispNum = 0; b1.dispAddr = 0;
    b1.auxReq  = 0; b1.auxNum  = 0; b1.auxAddr  = 0;
    b3.dispReq = 0; b3.dispNum = 0; b3.dispAddr = 0;
    b3.auxReq  = 0; b3.auxNum  = 0; b3.auxAddr  = 0;
    rst1 = 0; rst3 = 0;
    repeat (2) step();
    chk("d1_reset_outputs", 32'(outs1), 32'd0);
    chk("d3_reset_outputs", 32'(outs3), 32'd0);
    rst1 = 1; rst3 = 1;
    step();

    // Single uncontested display read.
    b1.dispReq = 1; b1.dispNum = 3; b1.dispAddr = 5;
    q1d.push_back('{romf(3'd3, 4'd5), -1});
    step();
    chk("t1_romReadEn", 32'(b1.romReadEn), 32'd1);
    chk("t1_romNum", 32'(b1.romNum), 32'd3);
    chk("t1_romAddr", 32'(b1.romAddr), 32'd5);
    chk("t1_dispAck", 32'(b1.dispAck), 32'd1);
    chk("t1_auxAck", 32'(b1.auxAck), 32'd0);
    chk("t1_busy_grant", 32'(b1.busy), 32'd1);
    b1.dispReq = 0;
    step();
    chk("t1_dispAck_pulse", 32'(b1.dispAck), 32'd0);
    chk("t1_romReadEn_off", 32'(b1.romReadEn), 32'd0);
    chk("t1_busy_flight", 32'(b1.busy), 32'd1);
    chk("t1_valid_early", 32'(b1.dispValid), 32'd0);
    step();
    chk("t1_dispValid", 32'(b1.dispValid), 32'd1);
    chk("t1_dispByte", 32'(b1.dispByte), 32'(romf(3'd3, 4'd5)));
    chk("t1_busy_done", 32'(b1.busy), 32'd0);
    step();

    // Both requesting from the same edge: disp, aux, disp, aux.
    dn = 3'd1; da = 4'd2; an = 3'd6; aa = 4'd9;
    b1.dispReq = 1; b1.dispNum = dn; b1.dispAddr = da;
    b1.auxReq  = 1; b1.auxNum  = an; b1.auxAddr  = aa;
    q1d.push_back('{romf(dn, da), -1});
    q1a.push_back('{romf(an, aa), -1});
    for (int k = 0; k < 4; k++) begin
      step();
      if (k % 2 == 0) begin
        chk("t2_dispAck", 32'(b1.dispAck), 32'd1);
        chk("t2_auxAck_lose", 32'(b1.auxAck), 32'd0);
        chk("t2_romAddr_disp", 32'(b1.romAddr), 32'(da));
        if (k < 2) begin
          da = 4'(da + 3);
          b1.dispAddr = da;
          q1d.push_back('{romf(dn, da), -1});
        end
      end else begin
        chk("t2_auxAck", 32'(b1.auxAck), 32'd1);
        chk("t2_dispAck_lose", 32'(b1.dispAck), 32'd0);
        chk("t2_romNum_aux", 32'(b1.romNum), 32'(an));
        chk("t2_romAddr_aux", 32'(b1.romAddr), 32'(aa));
        if (k < 2) begin
          aa = 4'(aa + 5);
          b1.auxAddr = aa;
          q1a.push_back('{romf(an, aa), -1});
        end
      end
    end
    b1.dispReq = 0; b1.auxReq = 0;
    repeat (4) step();
    chk("t2_disp_drained", 32'(q1d.size()), 32'd0);
    chk("t2_aux_drained", 32'(q1a.size()), 32'd0);

    // Starvation with STARVE_LIM=2: aux loses its ack edge then a display grant.
    b1.auxReq = 1; b1.auxNum = 2; b1.auxAddr = 7;
    q1a.push_back('{romf(3'd2, 4'd7), -1});
    step();
    chk("t3_auxAck_first", 32'(b1.auxAck), 32'd1);
    chk("t3_starve_clear0", 32'(b1.auxStarve), 32'd0);
    b1.auxAddr = 8;
    q1a.push_back('{romf(3'd2, 4'd8), -1});
    step();
    chk("t3_idle_edge", 32'(b1.romReadEn), 32'd0);
    chk("t3_starve_after1", 32'(b1.auxStarve), 32'd0);
    b1.dispReq = 1; b1.dispNum = 4; b1.dispAddr = 1;
    q1d.push_back('{romf(3'd4, 4'd1), -1});
    step();
    chk("t3_dispAck", 32'(b1.dispAck), 32'd1);
    chk("t3_starve_set", 32'(b1.auxStarve), 32'd1);
    b1.dispReq = 0;
    step();
    chk("t3_auxAck_second", 32'(b1.auxAck), 32'd1);
    chk("t3_romAddr_aux", 32'(b1.romAddr), 32'd8);
    chk("t3_starve_cleared", 32'(b1.auxStarve), 32'd0);
    b1.auxReq = 0;
    repeat (4) step();
    chk("t3_starve_stays0", 32'(b1.auxStarve), 32'd0);

    // Display request withdrawn before any edge samples it.
    b1.auxReq = 1; b1.auxNum = 5; b1.auxAddr = 3;
    q1a.push_back('{romf(3'd5, 4'd3), -1});
    step();
    chk("t4_auxAck", 32'(b1.auxAck), 32'd1);
    b1.auxReq = 0;
    #2 b1.dispReq = 1; b1.dispNum = 7; b1.dispAddr = 15;
    #4 b1.dispReq = 0;
    step();
    chk("t4_no_dispAck", 32'(b1.dispAck), 32'd0);
    chk("t4_no_read", 32'(b1.romReadEn), 32'd0);
    repeat (4) step();
    chk("t4_queues_empty", 32'(q1d.size() + q1a.size()), 32'd0);

    // Reset with two reads in flight.
    b1.dispReq = 1; b1.dispNum = 2; b1.dispAddr = 4;
    b1.auxReq  = 1; b1.auxNum  = 3; b1.auxAddr  = 6;
    step();
    chk("t5_dispAck", 32'(b1.dispAck), 32'd1);
    b1.dispReq = 0;
    step();
    chk("t5_auxAck", 32'(b1.auxAck), 32'd1);
    chk("t5_busy", 32'(b1.busy), 32'd1);
    b1.auxReq = 0;
    #1 rst1 = 0;
    #1 chk("t5_outs_in_reset", 32'(outs1), 32'd0);
    repeat (2) step();
    chk("t5_outs_held_reset", 32'(outs1), 32'd0);
    rst1 = 1;
    repeat (6) step();
    chk("t5_outs_after_release", 32'(outs1), 32'd0);

    // ROM_LAT=3: five alternating back-to-back grants.
    dn = 3'd0; da = 4'd1; an = 3'd7; aa = 4'd14;
    b3.dispReq = 1; b3.dispNum = dn; b3.dispAddr = da;
    b3.auxReq  = 1; b3.auxNum  = an; b3.auxAddr  = aa;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("t6_busy", 32'(b3.busy), 32'd1);
      if (k % 2 == 0) begin
        chk("t6_dispAck", 32'(b3.dispAck), 32'd1);
        chk("t6_romAddr_disp", 32'(b3.romAddr), 32'(da));
        q3d.push_back('{romf(dn, da), cyc + 4});
        da = 4'(da + 1);
        b3.dispAddr = da;
      end else begin
        chk("t6_auxAck", 32'(b3.auxAck), 32'd1);
        chk("t6_romAddr_aux", 32'(b3.romAddr), 32'(aa));
        q3a.push_back('{romf(an, aa), cyc + 4});
        aa = 4'(aa - 1);
        b3.auxAddr = aa;
      end
    end
    b3.dispReq = 0; b3.auxReq = 0;
    for (int j = 1; j <= 4; j++) begin
      step();
      chk("t6_busy_tail", 32'(b3.busy), 32'(j < 4));
    end
    step();
    chk("t6_disp_drained", 32'(q3d.size()), 32'd0);
    chk("t6_aux_drained", 32'(q3a.size()), 32'd0);
    chk("final_d1_queues", 32'(q1d.size() + q1a.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
